mult_div_unit: RTL
==================

# mult_div_unit

Iterative multiply/divide unit with HI/LO result registers for the MIPS datapath. It sits directly downstream of the register file and takes its two read-port values (`data1_out` = rs, `data2_out` = rt) as operands. It executes MULT, MULTU, DIV and DIVU over multiple cycles and exposes HI/LO for MFHI/MFLO. It also accepts MTHI/MTLO writes. The control unit stalls on `busy_out`.

## Interface
- `WIDTH`, 32, operand width; HI and LO are each `WIDTH` bits; must be ≥ 2.

- `clk`  in  1  system clock, all state changes on rising edge.
- `reset`  in  1  reset is synchronous and active-high.
- `start_in`  in  1  launch operation; sampled only in IDLE.
- `op_in`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start_in`.
- `opA_in`  in  WIDTH  rs value (multiplicand / dividend).
- `opB_in`  in  WIDTH  rt value (multiplier / divisor).
- `hiWrite_in`  in  1  MTHI: HI ← `writeData_in`.
- `loWrite_in`  in  1  MTLO: LO ← `writeData_in`.
- `writeData_in`  in  WIDTH  MTHI/MTLO data.
- `busy_out`  out  1  high while an operation is in flight.
- `done_out`  out  1  one-cycle pulse; HI/LO just updated by an operation.
- `divZero_out`  out  1  pulses with `done_out` when a DIV/DIVU had divisor 0.
- `hi_out`  out  WIDTH  HI register.
- `lo_out`  out  WIDTH  LO register.

## Operation
- States: IDLE, RUN, FIX.
- **IDLE → RUN** on an edge with `start_in` = 1. That edge latches:
  - the op;
  - operand magnitudes: signed ops take two's-complement absolute values; unsigned ops take raw values;
  - the result sign flags;
  - the divisor-zero flag.
  - The iteration counter clears to 0.
- **RUN**: one iteration per edge; the counter increments.
  - Multiply: shift-add, producing a 2·WIDTH-bit unsigned product.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - After the WIDTH-th RUN edge, state → FIX.
- **FIX → IDLE**: one edge applies sign correction and writes HI/LO.
  - Multiply: {HI,LO} = product, negated (2·WIDTH bits) if the operand signs differ (signed only).
  - Divide: LO = quotient, negated if signA ≠ signB. HI = remainder, taking the sign of the dividend (signed only).
  - Divisor 0: HI = original `opA_in`, LO = all ones; `divZero_out` pulses.
  - Overflow: signed 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0 (natural wrap, no trap).
- **MTHI/MTLO**:
  - Honoured only in IDLE and only when `start_in` = 0. Otherwise they are dropped.
  - Both may assert together; both registers are written on that edge.
- **`start_in` while busy**: ignored; no queuing.
- **Operand stability**: operands are not required to stay stable after the start edge.
- **Reset**:
  - Any state → IDLE on the next edge with `reset` = 1, aborting any operation in flight.
  - HI = 0, LO = 0, `busy_out` = 0, `done_out` = 0, `divZero_out` = 0.
  - `reset` has priority over start and MT writes.

## Timing
- **Start**: edge E0 samples `start_in`.
- **Busy**: `busy_out` (registered, = state ≠ IDLE) is high from after E0 through the cycle before E(WIDTH+1).
- **Iterations**: RUN edges E1…E(WIDTH).
- **Result**: FIX at edge E(WIDTH+1) writes HI/LO. In the following cycle `done_out` = 1 and `busy_out` = 0.
- **Latency**: WIDTH+1 edges from start to valid result (33 for WIDTH = 32).
- **Back-to-back**: a new start is accepted on the edge where `done_out` is high. Minimum issue interval is WIDTH+2 edges.
- **MT writes**: `hi_out`/`lo_out` reflect an MT write on the edge after it is sampled.
- **Outputs**: all outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- **MULTU**: 0xFFFFFFFF × 0xFFFFFFFF, start at E0 → HI = 0xFFFFFFFE, LO = 0x00000001 after E33. `done_out` is high for exactly one cycle. `busy_out` is high for 33 cycles.
- **MULT**: −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1.
- **MULT**: 0x80000000 × 0x80000000 → HI = 0x40000000, LO = 0.
- **DIV**: −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- **DIVU**: 7 / 2 → LO = 3, HI = 1.
- **DIV**: 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- **Divide by zero**: DIVU 0x12345678 / 0 → HI = 0x12345678, LO = 0xFFFFFFFF, `divZero_out` pulses with `done_out`.
- **Ignored inputs while busy**: a second `start_in` during RUN, and MTHI 0xAAAA during RUN, are both ignored; the first result is unaffected.
- **MT writes in IDLE**: MTHI 0xAAAA plus MTLO 0x5555 in IDLE → HI = 0xAAAA, LO = 0x5555 next edge.
- **Start beats MT**: start and `hiWrite_in` in the same cycle → the MT write is dropped.
- **Reset mid-operation**: `reset` at RUN iteration 10 → next edge `busy_out` = 0, HI = LO = 0, no `done_out`. A subsequent MULTU 6 × 7 gives LO = 42, HI = 0.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO result registers and MTHI/MTLO writes.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix-up in a final cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_in,
  input  logic [1:0]       op_in,
  input  logic [WIDTH-1:0] opA_in,
  input  logic [WIDTH-1:0] opB_in,
  input  logic             hiWrite_in,
  input  logic             loWrite_in,
  input  logic [WIDTH-1:0] writeData_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             divZero_out,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int unsigned W2 = 2 * WIDTH;
  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] orig_a_q, orig_a_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  // Operand magnitudes and signs; unsigned ops (op_in[0] = 1) use raw values.
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign sign_a = ~op_in[0] & opA_in[WIDTH-1];
  assign sign_b = ~op_in[0] & opB_in[WIDTH-1];
  assign mag_a  = sign_a ? (~opA_in + WIDTH'(1)) : opA_in;
  assign mag_b  = sign_b ? (~opB_in + WIDTH'(1)) : opB_in;

  // Multiply step: acc = {partial_hi, multiplier}, add multiplicand on LSB and shift right.
  logic [WIDTH:0]  mul_sum;
  logic [W2-1:0]   mul_next;

  assign mul_sum  = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: acc = {remainder, dividend/quotient}, shift left and trial-subtract.
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [W2-1:0]    div_next;

  assign div_shift = acc_q[W2-1:WIDTH-1];
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_rem   = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
  assign div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};

  // Sign-corrected results applied in FIX.
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  assign prod_fix = neg_quo_q ? (~acc_q + W2'(1)) : acc_q;
  assign quo_fix  = neg_quo_q ? (~acc_q[WIDTH-1:0] + WIDTH'(1)) : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_rem_q ? (~acc_q[W2-1:WIDTH] + WIDTH'(1)) : acc_q[W2-1:WIDTH];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_div_q   <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      opnd_q     <= '0;
      acc_q      <= '0;
      orig_a_q   <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dz_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      is_div_q   <= is_div_d;
      neg_quo_q  <= neg_quo_d;
      neg_rem_q  <= neg_rem_d;
      div_zero_q <= div_zero_d;
      opnd_q     <= opnd_d;
      acc_q      <= acc_d;
      orig_a_q   <= orig_a_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      dz_q       <= dz_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    is_div_d   = is_div_q;
    neg_quo_d  = neg_quo_q;
    neg_rem_d  = neg_rem_q;
    div_zero_d = div_zero_q;
    opnd_d     = opnd_q;
    acc_d      = acc_q;
    orig_a_d   = orig_a_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    dz_d       = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d    = RUN;
          cnt_d      = '0;
          is_div_d   = op_in[1];
          neg_quo_d  = sign_a ^ sign_b;
          neg_rem_d  = sign_a;
          div_zero_d = op_in[1] & (opB_in == '0);
          opnd_d     = op_in[1] ? mag_b : mag_a;
          acc_d      = {WIDTH'(0), (op_in[1] ? mag_a : mag_b)};
          orig_a_d   = opA_in;
        end else begin
          if (hiWrite_in) hi_d = writeData_in;
          if (loWrite_in) lo_d = writeData_in;
        end
      end
      RUN: begin
        acc_d = is_div_q ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (!is_div_q) begin
          hi_d = prod_fix[W2-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (div_zero_q) begin
          hi_d = orig_a_q;
          lo_d = '1;
          dz_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign divZero_out = dz_q;
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;

endmodule
